// File: rtl/yonga_lz4_frame_parser_pkg.sv
// Shared definitions for the LZ4 frame parser: state encoding, frame magic,
// error codes and the frame-descriptor flags kept for the rest of the frame.
package yonga_lz4_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MAGIC,
    S_FLG,
    S_BD,
    S_CSIZE,
    S_HC,
    S_BSIZE,
    S_BDATA,
    S_BCSUM,
    S_CCSUM,
    S_DONE,
    S_ERR
  } parse_state_t;

  localparam logic [31:0] LZ4_MAGIC = 32'h184D2204;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BAD_MAGIC = 3'd1,
    ERR_BAD_FLAGS = 3'd2,
    ERR_DICT_ID   = 3'd3,
    ERR_RAW_BLOCK = 3'd4,
    ERR_TOO_LARGE = 3'd5
  } err_code_t;

  typedef struct packed {
    logic bcsum;  // FLG[4]: per-block checksum follows every block
    logic csize;  // FLG[3]: 8-byte content size in the header
    logic ccsum;  // FLG[2]: content checksum after the end mark
  } frame_flags_t;

endpackage

// File: rtl/yonga_lz4_frame_parser.sv
// LZ4 frame parser: validates and strips header, block size words and checksums,
// forwarding only compressed payload bytes into the decoder's FIFO write port.
module yonga_lz4_frame_parser
  import yonga_lz4_pkg::*;
#(
  parameter int BLOCK_SIZE_W = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  input  logic [7:0] i_byte,
  output logic       o_compress_data_write,
  output logic [7:0] o_compress_data,
  input  logic       i_compress_fifo_full,
  output logic       o_decompress_start,
  output logic       o_frame_done,
  output logic       o_error,
  output logic [2:0] o_error_code,
  output logic       o_busy
);

  localparam logic [30:0]             MAX_BLOCK = 31'(1) << (BLOCK_SIZE_W - 1);
  localparam logic [BLOCK_SIZE_W-1:0] CNT_ONE   = BLOCK_SIZE_W'(1);

  parse_state_t            state;
  logic [2:0]              idx;
  logic [23:0]             bsize_sh;
  logic [BLOCK_SIZE_W-1:0] remaining;
  frame_flags_t            flags;
  err_code_t               err_code;
  logic [31:0]             bsize_word;
  logic                    xfer;

  assign o_busy       = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign o_byte_ready = o_busy && !(state == S_BDATA && i_compress_fifo_full);
  assign xfer         = i_byte_valid && o_byte_ready;

  // NOTE: the write strobe is combinational from the accept so the FIFO sees
  // it in the same cycle it reported not-full; a registered strobe would act
  // on a full flag that may already have changed.
  assign o_compress_data_write = xfer && (state == S_BDATA);
  assign o_compress_data       = i_byte;
  assign o_error_code          = err_code;

  // The fourth size byte is used straight from the input, so only three are held.
  assign bsize_word = {i_byte, bsize_sh};

  // NOTE: every register, including the block counter and shift register, is
  // in the async reset so a reset mid-frame leaves no stale block state;
  // state updates use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      idx                <= '0;
      bsize_sh           <= '0;
      remaining          <= '0;
      flags              <= '0;
      err_code           <= ERR_NONE;
      o_decompress_start <= 1'b0;
      o_frame_done       <= 1'b0;
      o_error            <= 1'b0;
    end else begin
      o_decompress_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_enable) begin
            state <= S_MAGIC;
            idx   <= '0;
          end
        end

        S_MAGIC: begin
          if (xfer) begin
            if (i_byte != LZ4_MAGIC[{idx[1:0], 3'b000} +: 8]) begin
              state    <= S_ERR;
              o_error  <= 1'b1;
              err_code <= ERR_BAD_MAGIC;
            end else if (idx == 3'd3) begin
              state <= S_FLG;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        S_FLG: begin
          if (xfer) begin
            idx <= '0;
            if (i_byte[7:6] != 2'b01 || i_byte[1]) begin
              state    <= S_ERR;
              o_error  <= 1'b1;
              err_code <= ERR_BAD_FLAGS;
            end else if (i_byte[0]) begin
              state    <= S_ERR;
              o_error  <= 1'b1;
              err_code <= ERR_DICT_ID;
            end else begin
              state <= S_BD;
              flags <= '{bcsum: i_byte[4], csize: i_byte[3], ccsum: i_byte[2]};
            end
          end
        end

        S_BD: begin
          if (xfer) begin
            idx <= '0;
            if (i_byte[7] || i_byte[3:0] != 4'h0) begin
              state    <= S_ERR;
              o_error  <= 1'b1;
              err_code <= ERR_BAD_FLAGS;
            end else begin
              state <= flags.csize ? S_CSIZE : S_HC;
            end
          end
        end

        S_CSIZE: begin
          if (xfer) begin
            if (idx == 3'd7) begin
              state <= S_HC;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        S_HC: begin
          if (xfer) begin
            state <= S_BSIZE;
            idx   <= '0;
          end
        end

        S_BSIZE: begin
          if (xfer) begin
            bsize_sh <= bsize_word[31:8];
            if (idx == 3'd3) begin
              idx <= '0;
              if (bsize_word == 32'h0) begin
                state        <= flags.ccsum ? S_CCSUM : S_DONE;
                o_frame_done <= !flags.ccsum;
              end else if (bsize_word[31]) begin
                state    <= S_ERR;
                o_error  <= 1'b1;
                err_code <= ERR_RAW_BLOCK;
              end else if (bsize_word[30:0] > MAX_BLOCK) begin
                state    <= S_ERR;
                o_error  <= 1'b1;
                err_code <= ERR_TOO_LARGE;
              end else begin
                state              <= S_BDATA;
                remaining          <= bsize_word[BLOCK_SIZE_W-1:0];
                o_decompress_start <= 1'b1;
              end
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        S_BDATA: begin
          if (xfer) begin
            // Leave at count 1 so the counter never wraps below zero.
            if (remaining == CNT_ONE) begin
              state <= flags.bcsum ? S_BCSUM : S_BSIZE;
              idx   <= '0;
            end
            remaining <= remaining - CNT_ONE;
          end
        end

        S_BCSUM: begin
          if (xfer) begin
            if (idx == 3'd3) begin
              state <= S_BSIZE;
              idx   <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        S_CCSUM: begin
          if (xfer) begin
            if (idx == 3'd3) begin
              state        <= S_DONE;
              o_frame_done <= 1'b1;
              idx          <= '0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        S_DONE, S_ERR: begin
          if (!i_enable) begin
            state        <= S_IDLE;
            idx          <= '0;
            flags        <= '0;
            o_frame_done <= 1'b0;
            o_error      <= 1'b0;
            err_code     <= ERR_NONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
